// File: rtl/mdio_slave_responder.sv
// mdio_slave_responder: clause-22 MDIO management target, PHY side.
// It oversamples MDC on the fabric clock. It decodes read and write frames
// addressed to PHY_ADDR and serves a 32 x 16-bit register file:
//   reg 0      control, RW; writing bit15 = 1 restores every RW register
//   reg 1      live phy_status, read-only
//   reg 2/3    PHY identifier, read-only
//   reg 4-31   general RW, reset to 0
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN: after a frame that completed
// to this PHY_ADDR, a single preamble 1 is enough to start the next frame.
`timescale 1ns/1ps

module mdio_slave_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter logic [15:0] CTRL_RST_VAL = 16'h1140
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic [15:0] phy_status,
    output logic [15:0] ctrl_reg,
    output logic        reg_wr_stb,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data
);

    typedef enum logic [2:0] {HUNT, ST, OP, PHYAD, REGAD, TA, DATA} state_t;

    // Pending pad action, armed on a rise_p and carried out on the next fall_p.
    typedef enum logic [1:0] {FA_NONE, FA_TA0, FA_DBIT, FA_REL} fall_act_t;

    localparam logic [5:0] PRE_FULL = 6'd32;

    // Preamble counter increment, saturating at a full 32-bit preamble.
    function automatic logic [5:0] sat_inc(input logic [5:0] cnt);
        return (cnt >= PRE_FULL) ? PRE_FULL : cnt + 6'd1;
    endfunction

    logic        mdc_p0, mdc_p1, mdc_p2;
    logic        mdio_p0, mdio_p1, mdio_p2;
    logic        rise_p, fall_p;
    logic        mdio_bit;

    state_t      state;
    fall_act_t   fall_act;
    logic [5:0]  pre_cnt;
    logic [3:0]  bit_cnt;
    logic [3:0]  field;
    logic        op_rd;
    logic        match;
    logic [4:0]  reg_addr;
    logic [15:0] rd_shift;
    logic [14:0] wr_shift;
    logic        pre_ok;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic        last_ok;
`endif

    logic [4:0]  shift_addr;
    logic [4:0]  rd_idx;
    logic [4:0]  wr_idx;
    logic [15:0] rd_word;
    logic [15:0] wr_word;
    logic        commit;
    logic [15:0] rw_regs [0:27];

    // ---- stage p0/p1: two-flop synchronizers; p2: edge-detect history ----
    // mdio is delayed one extra flop so mdio_bit lines up with rise_p.
    // Synchronize mdc/mdio and register the edge pulses (mdc edge -> pulse = 3 clk).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_p0  <= 1'b0;
            mdc_p1  <= 1'b0;
            mdc_p2  <= 1'b0;
            mdio_p0 <= 1'b1;
            mdio_p1 <= 1'b1;
            mdio_p2 <= 1'b1;
            rise_p  <= 1'b0;
            fall_p  <= 1'b0;
        end else begin
            mdc_p0  <= mdc;
            mdc_p1  <= mdc_p0;
            mdc_p2  <= mdc_p1;
            mdio_p0 <= mdio_i;
            mdio_p1 <= mdio_p0;
            mdio_p2 <= mdio_p1;
            rise_p  <= mdc_p1 & ~mdc_p2;
            fall_p  <= ~mdc_p1 & mdc_p2;
        end
    end

    assign mdio_bit   = mdio_p2;
    assign shift_addr = {field, mdio_bit};
    assign rd_idx     = shift_addr - 5'd4;
    assign wr_idx     = reg_addr - 5'd4;
    assign wr_word    = {wr_shift, mdio_bit};
    assign commit     = rise_p && (state == DATA) && (bit_cnt == 4'd15) && !op_rd && match;

    // Decide whether a 0 in HUNT may start a frame.
    always_comb begin
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        pre_ok = (pre_cnt == PRE_FULL) || (last_ok && (pre_cnt != 6'd0));
`else
        pre_ok = (pre_cnt == PRE_FULL);
`endif
    end

    // Read mux, indexed by the register address as it completes in REGAD.
    always_comb begin
        rd_word = 16'h0000;
        case (shift_addr)
            5'd0:    rd_word = ctrl_reg;
            5'd1:    rd_word = phy_status;
            5'd2:    rd_word = PHY_ID1;
            5'd3:    rd_word = PHY_ID2;
            default: rd_word = rw_regs[rd_idx];
        endcase
    end

    // ---- frame decode: bits taken on rise_p, pad updated on fall_p ----
    // Frame FSM with registered pad, strobe and write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            fall_act    <= FA_NONE;
            pre_cnt     <= '0;
            bit_cnt     <= '0;
            field       <= '0;
            op_rd       <= 1'b0;
            match       <= 1'b0;
            reg_addr    <= '0;
            rd_shift    <= '0;
            wr_shift    <= '0;
            mdio_o      <= 1'b0;
            mdio_t      <= 1'b1;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
            last_ok     <= 1'b0;
`endif
        end else begin
            reg_wr_stb <= 1'b0;
            if (rise_p) begin
                case (state)
                    HUNT: begin
                        if (mdio_bit) begin
                            pre_cnt <= sat_inc(pre_cnt);
                        end else begin
                            pre_cnt <= '0;
                            if (pre_ok) state <= ST;
                        end
                    end
                    ST: begin
                        if (mdio_bit) begin
                            state   <= OP;
                            bit_cnt <= '0;
                        end else begin
                            state <= HUNT;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                            last_ok <= 1'b0;
`endif
                        end
                    end
                    OP: begin
                        field <= shift_addr[3:0];
                        if (bit_cnt == 4'd1) begin
                            bit_cnt <= '0;
                            case ({field[0], mdio_bit})
                                2'b10: begin
                                    op_rd <= 1'b1;
                                    state <= PHYAD;
                                end
                                2'b01: begin
                                    op_rd <= 1'b0;
                                    state <= PHYAD;
                                end
                                default: begin
                                    state <= HUNT;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                                    last_ok <= 1'b0;
`endif
                                end
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PHYAD: begin
                        field <= shift_addr[3:0];
                        if (bit_cnt == 4'd4) begin
                            bit_cnt <= '0;
                            match   <= (shift_addr == PHY_ADDR);
                            state   <= REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    REGAD: begin
                        field <= shift_addr[3:0];
                        if (bit_cnt == 4'd4) begin
                            bit_cnt  <= '0;
                            reg_addr <= shift_addr;
                            // Snapshot: later phy_status changes cannot tear the frame.
                            rd_shift <= rd_word;
                            state    <= TA;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    TA: begin
                        // TA bits are never checked; a matching read takes the bus here.
                        if (bit_cnt == 4'd0) begin
                            bit_cnt <= 4'd1;
                            if (op_rd && match) fall_act <= FA_TA0;
                        end else begin
                            bit_cnt <= '0;
                            state   <= DATA;
                            if (op_rd && match) fall_act <= FA_DBIT;
                        end
                    end
                    DATA: begin
                        wr_shift <= wr_word[14:0];
                        if (bit_cnt == 4'd15) begin
                            bit_cnt <= '0;
                            pre_cnt <= '0;
                            state   <= HUNT;
                            if (op_rd && match) fall_act <= FA_REL;
                            if (commit) begin
                                reg_wr_stb  <= 1'b1;
                                reg_wr_addr <= reg_addr;
                                reg_wr_data <= wr_word;
                            end
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                            last_ok <= match;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (op_rd && match) fall_act <= FA_DBIT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end else if (fall_p) begin
                case (fall_act)
                    FA_TA0: begin
                        mdio_t <= 1'b0;
                        mdio_o <= 1'b0;
                    end
                    FA_DBIT: begin
                        mdio_o   <= rd_shift[15];
                        rd_shift <= {rd_shift[14:0], 1'b0};
                    end
                    FA_REL: begin
                        mdio_t <= 1'b1;
                        mdio_o <= 1'b0;
                    end
                    default: ;
                endcase
                fall_act <= FA_NONE;
            end
        end
    end

    // ---- register file: written in the same cycle the strobe is launched ----
    // Register file storage with soft-reset handling on reg 0 bit 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg <= CTRL_RST_VAL;
            for (int i = 0; i < 28; i++) rw_regs[i] <= 16'h0000;
        end else if (commit) begin
            if (reg_addr == 5'd0) begin
                if (wr_word[15]) begin
                    ctrl_reg <= CTRL_RST_VAL & 16'h7FFF;
                    for (int i = 0; i < 28; i++) rw_regs[i] <= 16'h0000;
                end else begin
                    ctrl_reg <= wr_word;
                end
            end else if (reg_addr >= 5'd4) begin
                rw_regs[wr_idx] <= wr_word;
            end
        end
    end

endmodule

// File: tb/tb_mdio_slave_responder.sv
// Directed bench for mdio_slave_responder acting as the MDIO master.
// MDC runs at 1/20 of clk, and the master changes MDIO on the MDC fall.
`timescale 1ns/1ps

module tb_mdio_slave_responder;

    logic        clk;
    logic        rst_n;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_t;
    logic [15:0] phy_status;
    logic [15:0] ctrl_reg;
    logic        reg_wr_stb;
    logic [4:0]  reg_wr_addr;
    logic [15:0] reg_wr_data;

    logic        master_en;
    logic        master_val;
    logic        mdio_line;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          t_falls  = 0;
    int          stb_cnt  = 0;
    logic [4:0]  stb_addr;
    logic [15:0] stb_data;
    logic [15:0] stb_ctrl;

    // Shared pad: master driver, else DUT when enabled, else pull-up.
    assign mdio_line = master_en ? master_val : (mdio_t ? 1'b1 : mdio_o);

    mdio_slave_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mdc         (mdc),
        .mdio_i      (mdio_line),
        .mdio_o      (mdio_o),
        .mdio_t      (mdio_t),
        .phy_status  (phy_status),
        .ctrl_reg    (ctrl_reg),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(negedge mdio_t) t_falls++;

    always @(negedge clk) begin
        if (reg_wr_stb) begin
            stb_cnt++;
            stb_addr = reg_wr_addr;
            stb_data = reg_wr_data;
            stb_ctrl = ctrl_reg;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mdc_bit(input logic b);
        master_val = b;
        #80 mdc = 1'b1;
        #80 mdc = 1'b0;
    endtask

    // One clause-22 frame; rst_bit >= 0 pulses rst_n during that read data bit.
    task automatic run_frame(input int pre, input logic rd, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] wdata,
                             input logic exp_drive, input int rst_bit,
                             output logic [15:0] rdata);
        rdata = 16'h0000;
        master_en = 1'b1;
        for (int i = 0; i < pre; i++) mdc_bit(1'b1);
        mdc_bit(1'b0);
        mdc_bit(1'b1);
        mdc_bit(rd);
        mdc_bit(!rd);
        for (int i = 4; i >= 0; i--) mdc_bit(phy[i]);
        for (int i = 4; i >= 0; i--) mdc_bit(ra[i]);
        if (!rd) begin
            mdc_bit(1'b1);
            mdc_bit(1'b0);
            for (int i = 15; i >= 0; i--) mdc_bit(wdata[i]);
            master_val = 1'b1;
        end else begin
            master_en = 1'b0;
            #80 mdc = 1'b1;
            check("ta1_mdio_t", mdio_t, 1);
            #80 mdc = 1'b0;
            #26 check("ta2_t_before_4clk", mdio_t, 1);
            #4  check("ta2_t_after_4clk", mdio_t, !exp_drive);
            #50 mdc = 1'b1;
            if (exp_drive) check("ta2_mdio_zero", mdio_line, 0);
            for (int i = 15; i >= 0; i--) begin
                #80 mdc = 1'b0;
                if (i == rst_bit) begin
                    #40 check("pre_rst_driving", mdio_t, 0);
                    rst_n = 1'b0;
                    #1 check("rst_release_t", mdio_t, 1);
                    check("rst_ctrl_reg", ctrl_reg, 16'h1140);
                    check("rst_mdio_o", mdio_o, 0);
                    #39 rst_n = 1'b1;
                    master_en  = 1'b1;
                    master_val = 1'b1;
                    phy_status = 16'hBEEF;
                    return;
                end
                #80 mdc = 1'b1;
                rdata[i] = mdio_line;
                if (i == 8) phy_status = 16'h1357;
            end
            #80 mdc = 1'b0;
            #80 check("release_t", mdio_t, 1);
            phy_status = 16'hBEEF;
            master_en  = 1'b1;
            master_val = 1'b1;
        end
    endtask

    typedef struct {
        logic        rd;
        logic [4:0]  phy;
        logic [4:0]  ra;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_stb;
        logic [15:0] exp_ctrl;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        logic [15:0] rdata;
        int          stb0;
        int          f0;
        logic        drv;

        vecs[0]  = '{1'b1, 5'd0, 5'd2,  16'h0000, 16'h0141, 1'b0, 16'h1140};
        vecs[1]  = '{1'b1, 5'd0, 5'd3,  16'h0000, 16'h0CC2, 1'b0, 16'h1140};
        vecs[2]  = '{1'b1, 5'd0, 5'd1,  16'h0000, 16'hBEEF, 1'b0, 16'h1140};
        vecs[3]  = '{1'b0, 5'd0, 5'd9,  16'hA5C3, 16'h0000, 1'b1, 16'h1140};
        vecs[4]  = '{1'b1, 5'd0, 5'd9,  16'h0000, 16'hA5C3, 1'b0, 16'h1140};
        vecs[5]  = '{1'b0, 5'd0, 5'd2,  16'hFFFF, 16'h0000, 1'b1, 16'h1140};
        vecs[6]  = '{1'b1, 5'd0, 5'd2,  16'h0000, 16'h0141, 1'b0, 16'h1140};
        vecs[7]  = '{1'b0, 5'd0, 5'd31, 16'h8001, 16'h0000, 1'b1, 16'h1140};
        vecs[8]  = '{1'b1, 5'd0, 5'd31, 16'h0000, 16'h8001, 1'b0, 16'h1140};
        vecs[9]  = '{1'b0, 5'd0, 5'd0,  16'h8000, 16'h0000, 1'b1, 16'h1140};
        vecs[10] = '{1'b1, 5'd0, 5'd9,  16'h0000, 16'h0000, 1'b0, 16'h1140};
        vecs[11] = '{1'b1, 5'd0, 5'd31, 16'h0000, 16'h0000, 1'b0, 16'h1140};
        vecs[12] = '{1'b1, 5'd0, 5'd0,  16'h0000, 16'h1140, 1'b0, 16'h1140};
        vecs[13] = '{1'b0, 5'd5, 5'd9,  16'h1234, 16'h0000, 1'b0, 16'h1140};
        vecs[14] = '{1'b1, 5'd5, 5'd0,  16'h0000, 16'hFFFF, 1'b0, 16'h1140};
        vecs[15] = '{1'b1, 5'd0, 5'd9,  16'h0000, 16'h0000, 1'b0, 16'h1140};
        vecs[16] = '{1'b0, 5'd0, 5'd0,  16'h0100, 16'h0000, 1'b1, 16'h0100};
        vecs[17] = '{1'b1, 5'd0, 5'd0,  16'h0000, 16'h0100, 1'b0, 16'h0100};
        vecs[18] = '{1'b0, 5'd0, 5'd4,  16'h0001, 16'h0000, 1'b1, 16'h0100};
        vecs[19] = '{1'b1, 5'd0, 5'd4,  16'h0000, 16'h0001, 1'b0, 16'h0100};

        rst_n      = 1'b0;
        mdc        = 1'b0;
        master_en  = 1'b1;
        master_val = 1'b1;
        phy_status = 16'hBEEF;
        repeat (3) @(negedge clk);
        check("reset_mdio_t", mdio_t, 1);
        check("reset_mdio_o", mdio_o, 0);
        check("reset_ctrl_reg", ctrl_reg, 16'h1140);
        check("reset_wr_stb", reg_wr_stb, 0);
        check("reset_wr_addr", reg_wr_addr, 0);
        check("reset_wr_data", reg_wr_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_mdio_t", mdio_t, 1);

        for (int v = 0; v < NV; v++) begin
            stb0 = stb_cnt;
            f0   = t_falls;
            drv  = vecs[v].rd && (vecs[v].phy == 5'd0);
            run_frame(32, vecs[v].rd, vecs[v].phy, vecs[v].ra, vecs[v].wdata, drv, -1, rdata);
            #160;
            if (vecs[v].rd) check($sformatf("v%0d_rd_data", v), rdata, vecs[v].exp_rd);
            check($sformatf("v%0d_t_falls", v), t_falls - f0, drv ? 1 : 0);
            check($sformatf("v%0d_stb_count", v), stb_cnt - stb0, vecs[v].exp_stb ? 1 : 0);
            if (vecs[v].exp_stb) begin
                check($sformatf("v%0d_stb_addr", v), stb_addr, vecs[v].ra);
                check($sformatf("v%0d_stb_data", v), stb_data, vecs[v].wdata);
                check($sformatf("v%0d_stb_ctrl", v), stb_ctrl, vecs[v].exp_ctrl);
            end
            check($sformatf("v%0d_ctrl_reg", v), ctrl_reg, vecs[v].exp_ctrl);
        end

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        // Previous frame completed to address 0, so a 1-bit preamble is enough.
        stb0 = stb_cnt;
        run_frame(1, 1'b0, 5'd0, 5'd11, 16'hCAFE, 1'b0, -1, rdata);
        #160;
        check("short_pre_stb", stb_cnt - stb0, 1);
        run_frame(32, 1'b1, 5'd0, 5'd11, 16'h0000, 1'b1, -1, rdata);
        #160;
        check("short_pre_readback", rdata, 16'hCAFE);
`else
        // 31 ones is one short of a preamble: the whole frame is ignored.
        stb0 = stb_cnt;
        run_frame(31, 1'b0, 5'd0, 5'd10, 16'h1234, 1'b0, -1, rdata);
        #160;
        check("short_pre_stb", stb_cnt - stb0, 0);
        run_frame(32, 1'b1, 5'd0, 5'd10, 16'h0000, 1'b1, -1, rdata);
        #160;
        check("short_pre_readback", rdata, 16'h0000);
`endif

        // Reset during read data bit 7, then normal frames must decode.
        run_frame(32, 1'b1, 5'd0, 5'd2, 16'h0000, 1'b1, 7, rdata);
        #160;
        check("post_rst_ctrl_reg", ctrl_reg, 16'h1140);
        f0 = t_falls;
        run_frame(32, 1'b1, 5'd0, 5'd2, 16'h0000, 1'b1, -1, rdata);
        #160;
        check("post_rst_read_id1", rdata, 16'h0141);
        check("post_rst_t_falls", t_falls - f0, 1);
        run_frame(32, 1'b1, 5'd0, 5'd4, 16'h0000, 1'b1, -1, rdata);
        #160;
        check("post_rst_reg4_cleared", rdata, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
